majority_serial_voter: RTL and testbench
========================================

// Module: majority_serial_voter
// PURPOSE
//  Serial front end for the 5-input majority function. Accepts votes one bit per
//  valid/ready handshake, packs N_VOTES of them into a frame, then presents the
//  majority decision, the ones-count and the packed vector with output backpressure.
//  Sits between a serial vote source and any consumer of majority_ckt-style results.
// PARAMETERS
//  N_VOTES  5                    votes per frame; must be odd and >= 3
//  CNT_W    $clog2(N_VOTES+1)    width of the ones-count and bit-index counters
// PORTS
//  clk        in   1        single clock; all state updates on the rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  clr        in   1        synchronous frame abort; highest priority after rst_n
//  in_valid   in   1        in_bit is valid this cycle
//  in_ready   out  1        voter can accept a vote this cycle
//  in_bit     in   1        vote; first accepted vote is x1, last is x[N_VOTES]
//  out_valid  out  1        frame result is valid
//  out_ready  in   1        consumer takes the result this cycle
//  out_z      out  1        majority: 1 iff ones-count >= N_VOTES/2+1
//  out_count  out  CNT_W    number of 1 votes in the frame
//  out_vec    out  N_VOTES  packed frame; bit i-1 holds x_i (x1 in bit 0)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=COLLECT, idx=0, ones=0, out_valid=0, out_z=0,
//    out_count=0, out_vec=0. in_ready=1 on the first cycle after release.
//  - Accept = in_valid & in_ready. Output handshake = out_valid & out_ready.
//  - COLLECT: in_ready=1, out_valid=0. On accept: vec[idx]<=in_bit,
//    ones<=ones+in_bit, idx<=idx+1. Accept with idx==N_VOTES-1 loads the result
//    registers (z from ones+in_bit, so the final vote counts) and goes to HOLD.
//  - HOLD: out_valid=1; out_z/out_count/out_vec are held stable until the output
//    handshake. in_ready=out_ready (combinational), so the first vote of the next
//    frame may be accepted in the same cycle as the handshake. When that happens,
//    the next state is COLLECT with idx=1, ones=in_bit and vec[0]=in_bit.
//    Without a same-cycle vote, the next state is COLLECT with idx=0, ones=0.
//  - Latency: out_valid rises on the cycle after the last vote is accepted.
//    Sustained throughput is N_VOTES votes per N_VOTES cycles when out_ready=1.
//  - out_vec bits not yet written in a frame are 0; vec is cleared when a frame starts.
//  - in_valid while in_ready=0 is ignored; the source must hold in_bit (AXI-style).
//  - clr=1: next state is COLLECT, idx=0, ones=0, vec=0, out_valid=0. Any accept
//    or output handshake in the clr cycle is discarded.
//  - rst_n asserted mid-frame or in HOLD: immediate return to reset values; the
//    partial frame is lost and no result is emitted.
//  - Arithmetic: ones and idx are CNT_W bits wide and cannot overflow because
//    idx <= N_VOTES-1. Threshold compare is unsigned against N_VOTES/2+1.
//  - Output registers change only on the frame-complete accept, clr, or reset.
//  - In HOLD, out_z/out_count/out_vec are not altered by the next frame's votes.
// STRUCTURE
//  - majority_defs.vh: state encodings ST_COLLECT=1'b0 and ST_HOLD=1'b1, and the
//    macro MAJ_THRESH(n)=(n/2+1). This file is shared with the combinational
//    majority_ckt and its bench.
//  - One sub-module, vote_accumulator: holds idx, ones and vec, with inputs
//    load/clear/seed. The FSM and output registers stay in the top module.
// TESTING
//  1. Reset, then votes 1,0,1,1,0 back-to-back, out_ready=1 -> one cycle later
//     out_valid=1, out_z=1, out_count=3, out_vec=5'b01101.
//  2. Votes 0,0,1,0,1 -> out_z=0, out_count=2, out_vec=5'b10100. Then hold
//     out_ready=0 for 4 cycles -> outputs stable and in_ready=0 throughout.
//  3. Exhaustive: all 32 frames, streamed continuously with out_ready=1 ->
//     out_z matches popcount>=3 for each frame, no bubbles, and the next frame's
//     first vote is accepted on the handshake cycle.
//  4. Randomised in_valid gaps and out_ready stalls over 1000 frames ->
//     scoreboard matches per frame, and no vote is lost or duplicated.
//  5. After 3 votes (1,1,1), pulse clr -> no out_valid. A following frame of
//     0,0,0,0,1 gives out_z=0, out_count=1, out_vec=5'b10000.
//  6. Assert rst_n low asynchronously, mid-clock, both mid-frame and in HOLD ->
//     outputs go to 0 immediately, and the next full frame is correct.

Source files
------------

// File: rtl/majority_serial_voter_pkg.sv
// Shared definitions for the serial majority voter: FSM states and vote threshold.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package majority_serial_voter_pkg;

    // Encodings match the ones used by the combinational majority_ckt and its bench.
    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    // Smallest ones-count that constitutes a majority of n votes.
    function automatic int maj_thresh(input int n);
        return n / 2 + 1;
    endfunction

endpackage

// File: rtl/vote_accumulator.sv
// Vote accumulator: bit index, running ones-count and packed vector of the current frame.
// Latency: state updates one cycle after load/seed/clear; *_upd outputs are combinational.
// Backpressure: none; the parent only pulses load/seed on an accepted vote.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clear           empty the frame (highest priority)
//   seed            start a new frame with vote as x1
//   load            append vote at position idx
//   vote            the vote being accepted this cycle
//   idx             position the next vote will occupy
//   ones_upd        ones-count including this cycle's vote
//   vec_upd         packed vector including this cycle's vote
module vote_accumulator #(
    parameter int N_VOTES = 5,
    parameter int CNT_W   = $clog2(N_VOTES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               seed,
    input  logic               load,
    input  logic               vote,
    output logic [CNT_W-1:0]   idx,
    output logic [CNT_W-1:0]   ones_upd,
    output logic [N_VOTES-1:0] vec_upd
);

    logic [CNT_W-1:0]   ones;
    logic [N_VOTES-1:0] vec;

    // The parent needs the post-vote totals on the frame-completing accept, so
    // they are exposed combinationally rather than a cycle later.
    always_comb begin
        ones_upd = ones + CNT_W'(vote);
        vec_upd  = vec | (N_VOTES'(vote) << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            ones <= '0;
            vec  <= '0;
        end else if (clear) begin
            idx  <= '0;
            ones <= '0;
            vec  <= '0;
        end else if (seed) begin
            // First vote of a frame arriving on the previous frame's handshake.
            idx  <= CNT_W'(1);
            ones <= CNT_W'(vote);
            vec  <= N_VOTES'(vote);
        end else if (load) begin
            idx  <= idx + CNT_W'(1);
            ones <= ones_upd;
            vec  <= vec_upd;
        end
    end

endmodule

// File: rtl/majority_serial_voter.sv
// Serial majority voter: packs N_VOTES one-bit votes into a frame and presents majority/count/vector.
// Latency: out_valid rises the cycle after the last vote of a frame is accepted.
// Backpressure: result held while out_ready=0; in_ready follows out_ready in HOLD so frames stream gap-free.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clr                   synchronous frame abort (drops any accept/handshake this cycle)
//   in_valid/in_ready     vote handshake, in_bit carries the vote (first accepted = x1)
//   out_valid/out_ready   result handshake
//   out_z                 1 iff out_count >= N_VOTES/2+1
//   out_count             number of 1 votes in the frame
//   out_vec               packed frame, x1 in bit 0
// N_VOTES must be odd and at least 3.
module majority_serial_voter
    import majority_serial_voter_pkg::*;
#(
    parameter int N_VOTES = 5,
    parameter int CNT_W   = $clog2(N_VOTES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_bit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_z,
    output logic [CNT_W-1:0]   out_count,
    output logic [N_VOTES-1:0] out_vec
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VOTES - 1);
    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(maj_thresh(N_VOTES));

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               out_hs;
    logic               frame_done;
    logic               acc_clear;
    logic               acc_seed;
    logic               acc_load;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   ones_upd;
    logic [N_VOTES-1:0] vec_upd;

    // clr masks both handshakes so nothing from the abort cycle survives.
    assign accept     = in_valid & in_ready & ~clr;
    assign out_hs     = out_valid & out_ready & ~clr;
    assign frame_done = accept & (state == ST_COLLECT) & (idx == LAST_IDX);

    // The accumulator is emptied as soon as a frame completes; the result lives
    // in the output registers, so HOLD can seed the next frame directly.
    // An accept while in HOLD can only coincide with the output handshake.
    assign acc_clear = clr | frame_done;
    assign acc_seed  = accept & (state == ST_HOLD);
    assign acc_load  = accept & (state == ST_COLLECT) & ~frame_done;

    vote_accumulator #(
        .N_VOTES (N_VOTES),
        .CNT_W   (CNT_W)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (acc_clear),
        .seed     (acc_seed),
        .load     (acc_load),
        .vote     (in_bit),
        .idx      (idx),
        .ones_upd (ones_upd),
        .vec_upd  (vec_upd)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ST_COLLECT;
        end else begin
            case (state)
                ST_COLLECT: if (frame_done) state_nxt = ST_HOLD;
                ST_HOLD:    if (out_hs)     state_nxt = ST_COLLECT;
                default:    state_nxt = ST_COLLECT;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        if (state == ST_HOLD) begin
            in_ready  = out_ready;
            out_valid = 1'b1;
        end
    end

    // Result registers: written only when a frame completes, so the next
    // frame's votes cannot disturb a result still waiting in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_z     <= 1'b0;
            out_count <= '0;
            out_vec   <= '0;
        end else if (clr) begin
            out_z     <= 1'b0;
            out_count <= '0;
            out_vec   <= '0;
        end else if (frame_done) begin
            out_z     <= (ones_upd >= THRESH);
            out_count <= ones_upd;
            out_vec   <= vec_upd;
        end
    end

endmodule

// File: tb/tb_majority_serial_voter.sv
module tb_majority_serial_voter;

    localparam int N  = 5;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic          in_bit;
    logic          out_valid;
    logic          out_ready;
    logic          out_z;
    logic [CW-1:0] out_count;
    logic [N-1:0]  out_vec;

    always #5 clk = ~clk;

    majority_serial_voter #(.N_VOTES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_count (out_count),
        .out_vec   (out_vec)
    );

    typedef struct {
        int z;
        int cnt;
        int vec;
    } res_t;

    // Reference model: accepted votes of the open frame, and finished results not yet consumed.
    int   votes[$];
    res_t pend[$];
    int   chk    = 0;
    int   errs   = 0;
    int   popped = 0;
    logic acc_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t make_result();
        res_t r;
        r.cnt = 0;
        r.vec = 0;
        for (int i = 0; i < N; i++) begin
            r.cnt += votes[i];
            r.vec |= votes[i] << i;
        end
        r.z = (r.cnt >= N / 2 + 1) ? 1 : 0;
        return r;
    endfunction

    // One clock: drive inputs, check at the falling edge, advance the model, land at posedge+1.
    task automatic step(input logic v, input logic b, input logic r, input logic c);
        logic exp_valid;
        logic exp_ready;
        in_valid  = v;
        in_bit    = b;
        out_ready = r;
        clr       = c;
        @(negedge clk);
        exp_valid = (pend.size() != 0);
        exp_ready = exp_valid ? r : 1'b1;
        check("out_valid", out_valid, exp_valid);
        check("in_ready", in_ready, exp_ready);
        if (exp_valid) begin
            check("out_z", out_z, pend[0].z);
            check("out_count", out_count, pend[0].cnt);
            check("out_vec", out_vec, pend[0].vec);
        end
        acc_last = 1'b0;
        if (c) begin
            votes.delete();
            pend.delete();
        end else begin
            if (exp_valid && r) begin
                void'(pend.pop_front());
                popped++;
            end
            if (v && exp_ready) begin
                votes.push_back(int'(b));
                acc_last = 1'b1;
                if (votes.size() == N) begin
                    pend.push_back(make_result());
                    votes.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [N-1:0] x, input logic r);
        for (int i = 0; i < N; i++) step(1'b1, x[i], r, 1'b0);
    endtask

    // Asynchronous reset asserted and released between clock edges.
    task automatic async_reset();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_z", out_z, 0);
        check("arst_out_count", out_count, 0);
        check("arst_out_vec", out_vec, 0);
        check("arst_in_ready", in_ready, 1);
        votes.delete();
        pend.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] fr;
        logic         cb;
        int           cyc;
        int           start;

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_z", out_z, 0);
        check("reset_out_count", out_count, 0);
        check("reset_out_vec", out_vec, 0);
        check("reset_in_ready", in_ready, 1);

        // Votes x1..x5 = 1,0,1,1,0 (x1 lands in bit 0).
        fr = 5'b01101;
        send_frame(fr, 1'b1);
        check("t1_out_valid", out_valid, 1);
        check("t1_out_z", out_z, 1);
        check("t1_out_count", out_count, 3);
        check("t1_out_vec", out_vec, 5'b01101);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Votes 0,0,1,0,1 then a 4-cycle output stall with a vote waiting.
        fr = 5'b10100;
        send_frame(fr, 1'b1);
        check("t2_out_z", out_z, 0);
        check("t2_out_count", out_count, 2);
        check("t2_out_vec", out_vec, 5'b10100);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // All 32 frames streamed back-to-back.
        for (int f = 0; f < 32; f++) begin
            fr = N'(f);
            send_frame(fr, 1'b1);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Abort a partial frame, then a fresh frame 0,0,0,0,1.
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        fr = 5'b10000;
        send_frame(fr, 1'b1);
        check("t5_out_z", out_z, 0);
        check("t5_out_count", out_count, 1);
        check("t5_out_vec", out_vec, 5'b10000);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-frame, then in HOLD, each followed by a clean frame.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        async_reset();
        fr = 5'b11001;
        send_frame(fr, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        fr = 5'b10111;
        send_frame(fr, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        async_reset();
        fr = 5'b01011;
        send_frame(fr, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Random input gaps, output stalls and occasional aborts.
        cb    = 1'($urandom_range(0, 1));
        cyc   = 0;
        start = popped;
        while ((popped - start) < 1000 && cyc < 40000) begin
            step(1'($urandom_range(0, 9) < 7), cb, 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 499) == 0));
            cyc++;
            if (acc_last) cb = 1'($urandom_range(0, 1));
        end
        check("rand_frames_done", ((popped - start) >= 1000) ? 1 : 0, 1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end

endmodule
